// File: rtl/narrow_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// narrow_sat : 32-bit to WIDTH-bit narrowing with optional saturation, 2-entry
//              result FIFO and overflow statistics.             Rev 1.0
// ---------------------------------------------------------------------------
module narrow_sat #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sext,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  input  logic             ovf_clr,
  output logic             ovf_sticky,
  output logic [7:0]       ovf_count
);

  localparam int EW = WIDTH + 1;

  logic [EW-1:0]    head;
  logic [EW-1:0]    tail;
  logic [1:0]       occ;
  logic             sign_ovf;
  logic             uns_ovf;
  logic             ovf;
  logic             push;
  logic             pop;
  logic             ovf_acc;
  logic [WIDTH-1:0] narrowed;
  logic [EW-1:0]    entry;

  always_comb begin
    sign_ovf = in_data[31:WIDTH-1] != {(33-WIDTH){in_data[31]}};
    uns_ovf  = in_data[31:WIDTH] != '0;
    ovf      = in_sext ? sign_ovf : uns_ovf;
    narrowed = in_data[WIDTH-1:0];
    if (ovf && in_sat) begin
      if (!in_sext)
        narrowed = '1;
      else if (in_data[31])
        narrowed = {1'b1, {(WIDTH-1){1'b0}}};
      else
        narrowed = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign entry     = {ovf, narrowed};
  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign ovf_acc   = push && ovf;
  assign out_data  = head[WIDTH-1:0];
  assign out_ovf   = head[WIDTH];

  // head is always the oldest entry; tail only holds data when occ == 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= entry;
          else             tail <= entry;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        // push is only possible below 2 entries and pop needs one, so occ == 1
        2'b11:   head <= entry;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= 8'd0;
    end else if (ovf_clr) begin
      ovf_sticky <= ovf_acc;
      ovf_count  <= ovf_acc ? 8'd1 : 8'd0;
    end else if (ovf_acc) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_narrow_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_narrow_sat : self-checking bench for narrow_sat (WIDTH = 16).  Rev 1.0
// ---------------------------------------------------------------------------
module tb_narrow_sat;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_sext;
  logic             in_sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             ovf_clr;
  logic             ovf_sticky;
  logic [7:0]       ovf_count;

  narrow_sat #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sext    (in_sext),
    .in_sat     (in_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        o;
  } res_t;

  typedef struct {
    logic [31:0] data;
    logic        sext;
    logic        sat;
    logic [15:0] exp_d;
    logic        exp_o;
  } vec_t;

  res_t       sb[$];
  int         passed = 0;
  int         total  = 0;
  logic [7:0] m_cnt;
  logic       m_sticky;
  int         accepts = 0;
  int         pops    = 0;
  int         max_occ = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // independent reference: range test on the integer value
  function automatic res_t model(input logic [31:0] d, input logic sx, input logic st);
    res_t r;
    r.d = d[15:0];
    if (sx) begin
      r.o = ($signed(d) > 32767) || ($signed(d) < -32768);
      if (r.o && st) r.d = d[31] ? 16'h8000 : 16'h7FFF;
    end else begin
      r.o = d > 32'h0000_FFFF;
      if (r.o && st) r.d = 16'hFFFF;
    end
    return r;
  endfunction

  // scoreboard / flag model; signals are stable at the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_cnt    = 8'd0;
      m_sticky = 1'b0;
    end else begin
      res_t e;
      chk("ovf_count", {24'd0, ovf_count}, {24'd0, m_cnt});
      chk("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, m_sticky});
      chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_data", {16'd0, out_data}, {16'd0, e.d});
        chk("sb_ovf", {31'd0, out_ovf}, {31'd0, e.o});
        pops++;
      end
      if (in_valid && in_ready) begin
        e = model(in_data, in_sext, in_sat);
        sb.push_back(e);
        accepts++;
        if (sb.size() > max_occ) max_occ = sb.size();
        if (ovf_clr) begin
          m_cnt    = e.o ? 8'd1 : 8'd0;
          m_sticky = e.o;
        end else if (e.o) begin
          m_sticky = 1'b1;
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
      end else if (ovf_clr) begin
        m_cnt    = 8'd0;
        m_sticky = 1'b0;
      end
    end
  end

  // called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [31:0] d, input logic sx, input logic st);
    int n = 0;
    in_data  = d;
    in_sext  = sx;
    in_sat   = st;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[12];
    int   p0;
    int   a0;

    vecs[0]  = '{32'h0001_2345, 1'b1, 1'b1, 16'h7FFF, 1'b1};
    vecs[1]  = '{32'hFFFF_7FFF, 1'b1, 1'b1, 16'h8000, 1'b1};
    vecs[2]  = '{32'hFFFF_8000, 1'b1, 1'b1, 16'h8000, 1'b0};
    vecs[3]  = '{32'h0000_FFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0};
    vecs[4]  = '{32'h0001_0000, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[5]  = '{32'h0001_0000, 1'b0, 1'b1, 16'hFFFF, 1'b1};
    vecs[6]  = '{32'h0000_7FFF, 1'b1, 1'b0, 16'h7FFF, 1'b0};
    vecs[7]  = '{32'h0000_8000, 1'b1, 1'b0, 16'h8000, 1'b1};
    vecs[8]  = '{32'h0000_8000, 1'b1, 1'b1, 16'h7FFF, 1'b1};
    vecs[9]  = '{32'h8000_0000, 1'b1, 1'b1, 16'h8000, 1'b1};
    vecs[10] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 16'hFFFF, 1'b0};
    vecs[11] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sext = 1'b0;
    in_sat = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    chk("rst_count", {24'd0, ovf_count}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table vectors, one in flight at a time; result is at head right after accept
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].data, vecs[i].sext, vecs[i].sat);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_data", i), {16'd0, out_data}, {16'd0, vecs[i].exp_d});
      chk($sformatf("vec%0d_ovf", i), {31'd0, out_ovf}, {31'd0, vecs[i].exp_o});
      if (i == 0) chk("vec0_count", {24'd0, ovf_count}, 32'd1);
    end
    idle(2);

    // backpressure: A,B fill the FIFO, C is held off
    out_ready = 1'b0;
    p0 = pops;
    send(32'h0000_0011, 1'b0, 1'b0);
    send(32'h0000_0022, 1'b0, 1'b0);
    in_data = 32'h0000_0033; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_held_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head_a", {16'd0, out_data}, 32'h11);
    @(posedge clk); #1;
    chk("bp_head_stable", {16'd0, out_data}, 32'h11);
    out_ready = 1'b1;
    send(32'h0000_0033, 1'b0, 1'b0);
    idle(4);
    chk("bp_pops", pops - p0, 32'd3);

    // streaming 20 words
    max_occ = 0;
    a0 = accepts;
    p0 = pops;
    in_valid = 1'b1; in_sext = 1'b1; in_sat = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'h0000_1000 * i + 32'hFFFF_C000;
      @(negedge clk);
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_accepts", accepts - a0, 32'd20);
    chk("stream_pops", pops - p0, 32'd19);
    chk("stream_max_occ", max_occ, 32'd1);
    idle(2);

    // saturating counter, then clear-with-overflow and clear alone
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    for (int i = 0; i < 260; i++) send(32'h0001_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("cnt_sat", {24'd0, ovf_count}, 32'd255);
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    send(32'h0002_0000, 1'b0, 1'b1);
    ovf_clr = 1'b0;
    chk("clr_ovf_count", {24'd0, ovf_count}, 32'd1);
    chk("clr_ovf_sticky", {31'd0, ovf_sticky}, 32'd1);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    chk("clr_only_count", {24'd0, ovf_count}, 32'd0);
    chk("clr_only_sticky", {31'd0, ovf_sticky}, 32'd0);
    idle(2);

    // async reset with two buffered overflow entries
    out_ready = 1'b0;
    send(32'h0005_0000, 1'b1, 1'b1);
    send(32'h0006_0000, 1'b1, 1'b0);
    chk("pre_rst_sticky", {31'd0, ovf_sticky}, 32'd1);
    chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_sticky", {31'd0, ovf_sticky}, 32'd0);
    chk("arst_count", {24'd0, ovf_count}, 32'd0);
    chk("arst_out_data", {16'd0, out_data}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    p0 = pops;
    send(32'h0000_1234, 1'b0, 1'b0);
    chk("post_rst_head", {16'd0, out_data}, 32'h1234);
    idle(4);
    chk("post_rst_pops", pops - p0, 32'd1);
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
